alu_share_arb: RTL and testbench

Two-port round-robin arbiter and multicycle sequencer for one shared ALU instance, mainly used for the M-extension multiply ops. Each requester presents a valid/ready request carrying a 5-bit ALU control code and two operands. The block registers the winning request and holds it stable on the ALU inputs for a configurable multicycle window. It then captures the ALU result and returns it on that requester's own valid/ready response channel. It sits between the EX-stage issue logic (port 0) and a secondary requester such as the address/auxiliary unit (port 1), in front of a single ALU.

---
 rtl/alu_share_arb.sv | 95 +++++++++
 tb/tb_alu_share_arb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Two-port round-robin front end for one shared multicycle ALU.
// It grants a request, holds the operands on the ALU for LAT cycles and returns the result to the owning port.
module alu_share_arb #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [4:0]  alu_crl,
  input  logic [31:0] alu_res,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t      state, state_nxt;
  logic [4:0]  op_q;
  logic [31:0] a_q, b_q, res_q;
  logic        owner, rr;
  logic [3:0]  cnt;
  logic        any_vld, gnt, hs;

  // Tie-break on rr only when both ports contend.
  always_comb begin
    any_vld    = req0_valid | req1_valid;
    gnt        = (req0_valid & req1_valid) ? rr : req1_valid;
    hs         = (state == IDLE) & any_vld;
    req0_ready = rst_n & hs & ~gnt;
    req1_ready = rst_n & hs & gnt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_vld) state_nxt = EXEC;
      EXEC:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (owner ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      owner <= 1'b0;
      rr    <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        op_q  <= gnt ? req1_op : req0_op;
        a_q   <= gnt ? req1_a  : req0_a;
        b_q   <= gnt ? req1_b  : req0_b;
        owner <= gnt;
        rr    <= ~gnt;
        cnt   <= CNT_INIT;
      end else if (state == EXEC) begin
        // alu_res is a LAT-cycle multicycle path from op_q/a_q/b_q.
        if (cnt == 4'd0) res_q <= alu_res;
        else             cnt   <= cnt - 4'd1;
      end
    end
  end

  assign rsp0_valid = (state == RESP) & ~owner;
  assign rsp1_valid = (state == RESP) & owner;
  assign rsp0_data  = res_q;
  assign rsp1_data  = res_q;
  assign alu_op1    = a_q;
  assign alu_op2    = b_q;
  assign alu_crl    = op_q;
  assign busy       = (state != IDLE);
endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized bench for alu_share_arb: behavioural ALU plus a transaction-level model
// of grant order, response timing and held operands, checked every cycle.
module tb_alu_share_arb;
  localparam int LAT = 2;
  localparam logic [4:0] OP_ADD = 5'h00, OP_MUL = 5'h08, OP_MULH = 5'h09,
                         OP_MULHSU = 5'h0A, OP_MULHU = 5'h0B;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [4:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid, rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_data, rsp1_data, alu_op1, alu_op2, alu_res;
  logic [4:0]  alu_crl;
  logic        busy;

  int n_chk = 0, n_err = 0;

  alu_share_arb #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_crl(alu_crl), .alu_res(alu_res), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    p  = 64'h0;
    case (op)
      OP_ADD:    return a + b;
      OP_MUL:    return a * b;
      OP_MULH:   begin p = sa * sb;                  return p[63:32]; end
      OP_MULHSU: begin p = sa * {32'h0, b};          return p[63:32]; end
      OP_MULHU:  begin p = {32'h0, a} * {32'h0, b};  return p[63:32]; end
      default:   return 32'h0;
    endcase
  endfunction

  always_comb alu_res = alu_fn(alu_crl, alu_op1, alu_op2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: one operation in flight, aged in cycles since its handshake.
  bit          m_busy, m_rr, m_owner;
  int          m_age;
  logic [4:0]  m_op;
  logic [31:0] m_a, m_b, m_data;
  bit          grants[$];
  bit          acc0, acc1, got0, got1, cur_rv0;
  logic [31:0] last0, last1, cur_d0;

  task automatic step();
    bit e_r0, e_r1, e_rv, win;
    acc0 = 0; acc1 = 0; got0 = 0; got1 = 0;
    @(negedge clk);
    if (!rst_n) begin
      m_busy = 0; m_rr = 0; m_owner = 0; m_age = 0;
      m_op = '0; m_a = '0; m_b = '0;
    end
    e_r0 = rst_n && !m_busy && req0_valid && (!req1_valid || !m_rr);
    e_r1 = rst_n && !m_busy && req1_valid && (!req0_valid || m_rr);
    e_rv = m_busy && (m_age > LAT);
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    chk("rsp0_valid", rsp0_valid, e_rv && !m_owner);
    chk("rsp1_valid", rsp1_valid, e_rv && m_owner);
    chk("busy", busy, m_busy);
    chk("alu_op1", alu_op1, m_a);
    chk("alu_op2", alu_op2, m_b);
    chk("alu_crl", alu_crl, m_op);
    if (e_rv) chk("rsp_data", m_owner ? rsp1_data : rsp0_data, m_data);
    cur_rv0 = rsp0_valid; cur_d0 = rsp0_data;
    if (rsp0_valid && rsp0_ready) begin got0 = 1; last0 = rsp0_data; end
    if (rsp1_valid && rsp1_ready) begin got1 = 1; last1 = rsp1_data; end
    if (rst_n) begin
      if (!m_busy) begin
        if (e_r0 || e_r1) begin
          win = e_r1;
          grants.push_back(win);
          acc0 = e_r0; acc1 = e_r1;
          m_busy = 1; m_owner = win; m_rr = !win; m_age = 1;
          m_op = win ? req1_op : req0_op;
          m_a  = win ? req1_a  : req0_a;
          m_b  = win ? req1_b  : req0_b;
          m_data = alu_fn(m_op, m_a, m_b);
        end
      end else if (e_rv && (m_owner ? rsp1_ready : rsp0_ready)) m_busy = 0;
      else m_age++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic run_op(input bit p, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    if (p) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; rsp1_ready = 1; end
    else   begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; rsp0_ready = 1; end
    for (int i = 0; i < 20; i++) begin step(); if (p ? acc1 : acc0) break; end
    chk({tag, "_acc"}, p ? acc1 : acc0, 1);
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 40; i++) begin step(); if (p ? got1 : got0) break; end
    chk({tag, "_rsp"}, p ? got1 : got0, 1);
    chk(tag, p ? last1 : last0, exp);
  endtask

  function automatic logic [4:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return OP_ADD;
      1: return OP_MUL;
      2: return OP_MULH;
      3: return OP_MULHSU;
      4: return OP_MULHU;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    // Reset state, then immediate grant on release.
    step(); step();
    req0_valid = 1; req0_op = OP_MUL; req0_a = 32'd7; req0_b = 32'hFFFFFFFD; rsp0_ready = 1;
    step();
    chk("rst_no_ready", acc0, 0);
    rst_n = 1;
    step();
    chk("rel_ready0", acc0, 1);
    req0_valid = 0;
    for (int i = 0; i < 20; i++) begin step(); if (got0) break; end
    chk("mul_rsp", got0, 1);
    chk("mul_data", last0, 32'hFFFFFFEB);

    run_op(1, OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
    run_op(1, OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh");
    run_op(1, OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
    run_op(0, 5'h1F,     32'h12345678, 32'h9, 32'h0, "unknown_op");

    // Contention from reset: grants must alternate starting at port 0.
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    do_reset();
    grants.delete();
    for (int i = 0; i < 5 * (LAT + 2); i++) begin
      step();
      if (acc0) begin req0_op = rnd_op(); req0_a = $urandom; req0_b = $urandom; end
      if (acc1) begin req1_op = rnd_op(); req1_a = $urandom; req1_b = $urandom; end
    end
    chk("cont_count", 32'(grants.size()), 5);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("cont_order", grants[i], i % 2);
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 10; i++) step();

    // Backpressure on port 0 while port 1 waits.
    req0_valid = 1; req0_op = OP_MUL; req0_a = 32'd3; req0_b = 32'd5; rsp0_ready = 0;
    for (int i = 0; i < 20; i++) begin step(); if (acc0) break; end
    chk("bp_acc0", acc0, 1);
    req0_valid = 0;
    req1_valid = 1; req1_op = OP_ADD; req1_a = 32'd1; req1_b = 32'd2;
    for (int i = 0; i < 20; i++) begin step(); if (cur_rv0) break; end
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_vld", cur_rv0, 1);
      chk("bp_data", cur_d0, 32'd15);
      chk("bp_no_acc1", acc1, 0);
    end
    rsp0_ready = 1;
    step();
    chk("bp_hs", got0, 1);
    step();
    chk("bp_acc1", acc1, 1);
    req1_valid = 0;
    for (int i = 0; i < 10; i++) step();

    // Reset two cycles after a handshake discards the op.
    req1_valid = 1; req1_op = OP_MUL; req1_a = 32'd9; req1_b = 32'd9;
    for (int i = 0; i < 20; i++) begin step(); if (acc1) break; end
    chk("mid_acc1", acc1, 1);
    req1_valid = 0;
    step();
    rst_n = 0;
    req0_valid = 1; req1_valid = 1;
    step();
    chk("mid_no_rsp", got1, 0);
    step();
    rst_n = 1;
    step();
    chk("mid_gnt0", acc0, 1);
    req0_valid = 0; req1_valid = 0;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_op = rnd_op(); req0_a = $urandom; req0_b = $urandom;
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_op = rnd_op(); req1_a = $urandom; req1_b = $urandom;
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
